cpc_key_matrix: RTL and testbench
=================================

CPC_KEY_MATRIX -- requirements
Module: cpc_key_matrix

Interface
REQ-001 SHALL have clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have key_strobe  in  1  one-cycle pulse qualifying key_code, key_pressed and key_extended.
REQ-004 SHALL have key_pressed  in  1  1 = make, 0 = break.
REQ-005 SHALL have key_extended  in  1  1 = code was E0-prefixed.
REQ-006 SHALL have key_code  in  8  PS/2 set-2 scan code.
REQ-007 SHALL have joy1, joy2  in  7 each  active-high; bit0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2, 6 fire3.
REQ-008 SHALL have Y  in  4  matrix row select, driven by PPI port C[3:0].
REQ-009 SHALL have X  out  8  active-low column data for the selected row, feeding PSG port A.
REQ-010 SHALL have key_nmi  out  1  one-cycle pulse on F11 make.
REQ-011 SHALL have Fn  out  10  level per function key F1..F10; bit0 = F1.

Function
REQ-012 SHALL hold a 10x8 matrix register, active-low (1 = released).
REQ-013 SHALL register {key_extended, key_code, key_pressed} in stage 1 on the strobe edge, translate in stage 2, and update the matrix bit on the second rising edge after strobe.
REQ-014 SHALL accept back-to-back strobes on consecutive cycles with no loss; updates SHALL apply in arrival order.
REQ-015 SHALL ignore codes with no mapping; matrix, Fn and key_nmi stay unchanged.
REQ-016 SHALL use these minimum mappings (row/bit): E0-75 up = 0/0; 5A Return = 2/2; 29 Space = 5/7; 76 Esc = 8/2; 1C A = 8/5.
REQ-017 SHALL treat a non-extended code and its E0-prefixed code as distinct keys.
REQ-018 SHALL set X combinationally to the selected matrix row; Y = 10..15 SHALL give X = FF.
REQ-019 SHALL AND the row-9 bits 0..5 with ~{joy1 fire1, fire2, right, left, down, up} (bit0 up, 1 down, 2 left, 3 right, 4 fire2, 5 fire1).
REQ-020 SHALL AND row 6 with joy2 using the same bit mapping.
REQ-021 SHALL clear joystick contributions as soon as the joy input drops; matrix key state is unaffected.
REQ-022 SHALL set or clear the Fn bit on F1..F10 make or break, with the same latency as matrix updates.
REQ-023 SHALL emit key_nmi for exactly one cycle on F11 (code 78) make when F11 was released; typematic repeats SHALL NOT re-pulse; break re-arms.
REQ-024 SHALL make a repeated make of an already-pressed key idempotent, and a break of a released key a no-op.

Reset
REQ-025 SHALL force all matrix bits to 1, Fn = 0, key_nmi = 0, both pipeline valid flags = 0, and F11 state = released while reset is high.
REQ-026 SHALL discard strobes arriving during reset or still in flight when reset asserts.
REQ-027 SHALL need no strobe after reset release; the first strobe is processed normally.

Structure
REQ-028 SHALL place MATRIX_ROWS = 10, the F11 code, and the row/bit constants for joystick rows 6 and 9 in the shared package cpc_kbd_pkg.
REQ-029 SHALL contain one combinational sub-module, cpc_keymap: input {extended, code}; outputs valid, row[3:0], bit[2:0], fn_idx[3:0], fn_valid.
REQ-030 SHALL keep all sequential logic (pipeline, matrix, Fn, F11 edge detect) in cpc_key_matrix.

Verification
REQ-031 SHALL cover: strobe make 1C, Y = 8 -> X = DF two edges after strobe; then break 1C -> X = FF.
REQ-032 SHALL cover: strobes make 29 and make E0-75 on consecutive cycles -> Y = 5 gives X = 7F, Y = 0 gives X = FE.
REQ-033 SHALL cover: joy1 = 7'h11 (right+fire1), Y = 9 -> X = D7; joy1 = 0 -> X = FF; Y = 12 -> X = FF.
REQ-034 SHALL cover: make 78 three times -> exactly one key_nmi pulse; break 78 then make 78 -> second pulse.
REQ-035 SHALL cover: make 05 (F1) -> Fn = 001; reset asserted mid-pipeline after a make 5A strobe -> all rows FF, Fn = 000, no key_nmi after release.
REQ-036 SHALL cover: unmapped code 0F make -> every row stays FF.

Source files
------------

// File: rtl/cpc_kbd_pkg.sv
// Shared constants, types and helpers for the CPC keyboard matrix.
package cpc_kbd_pkg;

  localparam int unsigned MATRIX_ROWS = 10;
  localparam int unsigned ROW_W       = 4;
  localparam int unsigned COL_W       = 3;
  localparam int unsigned FN_KEYS     = 10;
  localparam int unsigned FN_W        = 4;
  localparam int unsigned CODE_W      = 8;
  localparam int unsigned JOY_W       = 7;

  // F11 make/break drives the NMI button
  localparam logic [CODE_W-1:0] F11_CODE = 8'h78;

  // Matrix rows shared with the joysticks
  localparam logic [ROW_W-1:0] JOY1_ROW = 4'd9;
  localparam logic [ROW_W-1:0] JOY2_ROW = 4'd6;

  // Bit positions on the joystick inputs
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_FIRE1 = 4;
  localparam int unsigned JOY_FIRE2 = 5;

  // Bit positions of the joystick lines inside a matrix row
  localparam int unsigned JBIT_UP    = 0;
  localparam int unsigned JBIT_DOWN  = 1;
  localparam int unsigned JBIT_LEFT  = 2;
  localparam int unsigned JBIT_RIGHT = 3;
  localparam int unsigned JBIT_FIRE2 = 4;
  localparam int unsigned JBIT_FIRE1 = 5;

  // Captured keyboard event
  typedef struct packed {
    logic              extended;
    logic [CODE_W-1:0] code;
    logic              pressed;
  } key_evt_t;

  // Matrix position of a translated key
  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } key_pos_t;

  // Build a valid matrix position
  function automatic key_pos_t key_at(input int unsigned r, input int unsigned c);
    key_pos_t p;
    p.valid = 1'b1;
    p.row   = ROW_W'(r);
    p.col   = COL_W'(c);
    return p;
  endfunction

  // Active-low row mask for a joystick (fire3 has no matrix line)
  function automatic logic [7:0] joy_row_mask(input logic [5:0] joy);
    logic [7:0] m;
    m             = '1;
    m[JBIT_UP]    = ~joy[JOY_UP];
    m[JBIT_DOWN]  = ~joy[JOY_DOWN];
    m[JBIT_LEFT]  = ~joy[JOY_LEFT];
    m[JBIT_RIGHT] = ~joy[JOY_RIGHT];
    m[JBIT_FIRE2] = ~joy[JOY_FIRE2];
    m[JBIT_FIRE1] = ~joy[JOY_FIRE1];
    return m;
  endfunction

endpackage

// File: rtl/cpc_keymap.sv
// PS/2 set-2 scan code to CPC matrix position / function key translation.
module cpc_keymap
  import cpc_kbd_pkg::*;
(
  input  logic              extended,
  input  logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [FN_W-1:0]   fn_idx,
  output logic              fn_valid
);

  key_pos_t pos;

  // Matrix lookup; extended and plain codes are separate keys
  always_comb begin
    pos = '0;
    case ({extended, code})
      // row 0: cursor keys and keypad
      9'h175: pos = key_at(0, 0);
      9'h174: pos = key_at(0, 1);
      9'h172: pos = key_at(0, 2);
      9'h07D: pos = key_at(0, 3);
      9'h074: pos = key_at(0, 4);
      9'h07A: pos = key_at(0, 5);
      9'h15A: pos = key_at(0, 6);
      9'h071: pos = key_at(0, 7);
      // row 1
      9'h16B: pos = key_at(1, 0);
      9'h111: pos = key_at(1, 1);
      9'h06C: pos = key_at(1, 2);
      9'h075: pos = key_at(1, 3);
      9'h073: pos = key_at(1, 4);
      9'h069: pos = key_at(1, 5);
      9'h072: pos = key_at(1, 6);
      9'h070: pos = key_at(1, 7);
      // row 2
      9'h171: pos = key_at(2, 0);
      9'h05B: pos = key_at(2, 1);
      9'h05A: pos = key_at(2, 2);
      9'h05D: pos = key_at(2, 3);
      9'h06B: pos = key_at(2, 4);
      9'h012: pos = key_at(2, 5);
      9'h059: pos = key_at(2, 5);
      9'h00E: pos = key_at(2, 6);
      9'h014: pos = key_at(2, 7);
      9'h114: pos = key_at(2, 7);
      // row 3
      9'h055: pos = key_at(3, 0);
      9'h04E: pos = key_at(3, 1);
      9'h054: pos = key_at(3, 2);
      9'h04D: pos = key_at(3, 3);
      9'h04C: pos = key_at(3, 4);
      9'h052: pos = key_at(3, 5);
      9'h04A: pos = key_at(3, 6);
      9'h049: pos = key_at(3, 7);
      // row 4
      9'h045: pos = key_at(4, 0);
      9'h046: pos = key_at(4, 1);
      9'h044: pos = key_at(4, 2);
      9'h043: pos = key_at(4, 3);
      9'h04B: pos = key_at(4, 4);
      9'h042: pos = key_at(4, 5);
      9'h03A: pos = key_at(4, 6);
      9'h041: pos = key_at(4, 7);
      // row 5
      9'h03E: pos = key_at(5, 0);
      9'h03D: pos = key_at(5, 1);
      9'h03C: pos = key_at(5, 2);
      9'h035: pos = key_at(5, 3);
      9'h033: pos = key_at(5, 4);
      9'h03B: pos = key_at(5, 5);
      9'h031: pos = key_at(5, 6);
      9'h029: pos = key_at(5, 7);
      // row 6 (shared with joystick 2)
      9'h036: pos = key_at(6, 0);
      9'h02E: pos = key_at(6, 1);
      9'h02D: pos = key_at(6, 2);
      9'h02C: pos = key_at(6, 3);
      9'h034: pos = key_at(6, 4);
      9'h02B: pos = key_at(6, 5);
      9'h032: pos = key_at(6, 6);
      9'h02A: pos = key_at(6, 7);
      // row 7
      9'h025: pos = key_at(7, 0);
      9'h026: pos = key_at(7, 1);
      9'h024: pos = key_at(7, 2);
      9'h01D: pos = key_at(7, 3);
      9'h01B: pos = key_at(7, 4);
      9'h023: pos = key_at(7, 5);
      9'h021: pos = key_at(7, 6);
      9'h022: pos = key_at(7, 7);
      // row 8
      9'h016: pos = key_at(8, 0);
      9'h01E: pos = key_at(8, 1);
      9'h076: pos = key_at(8, 2);
      9'h015: pos = key_at(8, 3);
      9'h00D: pos = key_at(8, 4);
      9'h01C: pos = key_at(8, 5);
      9'h058: pos = key_at(8, 6);
      9'h01A: pos = key_at(8, 7);
      // row 9: only DEL is a key, the rest belongs to joystick 1
      9'h066: pos = key_at(9, 7);
      default: pos = '0;
    endcase
  end

  // Function key lookup, F1..F10
  always_comb begin
    fn_valid = 1'b1;
    fn_idx   = '0;
    case ({extended, code})
      9'h005: fn_idx = FN_W'(0);
      9'h006: fn_idx = FN_W'(1);
      9'h004: fn_idx = FN_W'(2);
      9'h00C: fn_idx = FN_W'(3);
      9'h003: fn_idx = FN_W'(4);
      9'h00B: fn_idx = FN_W'(5);
      9'h083: fn_idx = FN_W'(6);
      9'h00A: fn_idx = FN_W'(7);
      9'h001: fn_idx = FN_W'(8);
      9'h009: fn_idx = FN_W'(9);
      default: fn_valid = 1'b0;
    endcase
  end

  assign valid = pos.valid;
  assign row   = pos.row;
  assign col   = pos.col;

endmodule

// File: rtl/cpc_key_matrix.sv
// CPC 10x8 keyboard matrix fed by PS/2 events, with joystick overlay,
// function-key levels and an F11 NMI pulse.
module cpc_key_matrix
  import cpc_kbd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                key_strobe,
  input  logic                key_pressed,
  input  logic                key_extended,
  input  logic [CODE_W-1:0]   key_code,
  input  logic [JOY_W-1:0]    joy1,
  input  logic [JOY_W-1:0]    joy2,
  input  logic [ROW_W-1:0]    Y,
  output logic [7:0]          X,
  output logic                key_nmi,
  output logic [FN_KEYS-1:0]  Fn
);

  key_evt_t                        s1_evt;
  logic                            s1_valid;
  logic                            s2_valid;
  logic                            s2_nmi;
  logic                            f11_down;
  logic [MATRIX_ROWS-1:0][7:0]     matrix;

  logic                            map_valid;
  logic [ROW_W-1:0]                map_row;
  logic [COL_W-1:0]                map_col;
  logic [FN_W-1:0]                 map_fn_idx;
  logic                            map_fn_valid;
  logic                            s1_is_f11;

  // Fire3 has no line on the CPC joystick port
  logic                            unused_fire3;
  assign unused_fire3 = joy1[6] ^ joy2[6];

  cpc_keymap u_keymap (
    .extended (s1_evt.extended),
    .code     (s1_evt.code),
    .valid    (map_valid),
    .row      (map_row),
    .col      (map_col),
    .fn_idx   (map_fn_idx),
    .fn_valid (map_fn_valid)
  );

  assign s1_is_f11 = !s1_evt.extended && (s1_evt.code == F11_CODE);

  // Stage 1: capture the raw event on the strobe edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_evt   <= '0;
    end else begin
      s1_valid <= key_strobe;
      if (key_strobe) begin
        s1_evt <= '{extended: key_extended, code: key_code, pressed: key_pressed};
      end
    end
  end

  // Stage 2: apply the translated event to matrix, Fn and F11 state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matrix   <= '1;
      Fn       <= '0;
      f11_down <= 1'b0;
      s2_valid <= 1'b0;
      s2_nmi   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_nmi   <= s1_valid && s1_is_f11 && s1_evt.pressed && !f11_down;
      if (s1_valid && map_valid) begin
        matrix[map_row][map_col] <= ~s1_evt.pressed;
      end
      if (s1_valid && map_fn_valid) begin
        Fn[map_fn_idx] <= s1_evt.pressed;
      end
      if (s1_valid && s1_is_f11) begin
        f11_down <= s1_evt.pressed;
      end
    end
  end

  // Only a fresh F11 press produces the pulse; repeats are filtered by f11_down
  assign key_nmi = s2_valid & s2_nmi;

  // Column read-back for the selected row with joystick overlay
  always_comb begin
    X = 8'hFF;
    if (Y < ROW_W'(MATRIX_ROWS)) begin
      X = matrix[Y];
    end
    if (Y == JOY1_ROW) begin
      X = X & joy_row_mask(joy1[5:0]);
    end
    if (Y == JOY2_ROW) begin
      X = X & joy_row_mask(joy2[5:0]);
    end
  end

endmodule

// File: tb/tb_cpc_key_matrix.sv
// Bench for cpc_key_matrix: directed scenarios plus randomized traffic
// checked every cycle against an event-level model.
module tb_cpc_key_matrix;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_strobe = 1'b0;
  logic       key_pressed = 1'b0;
  logic       key_extended = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [6:0] joy1 = 7'h00;
  logic [6:0] joy2 = 7'h00;
  logic [3:0] Y = 4'h0;
  logic [7:0] X;
  logic       key_nmi;
  logic [9:0] Fn;

  always #5 clk = ~clk;

  cpc_key_matrix dut (
    .clk          (clk),
    .reset        (reset),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .joy1         (joy1),
    .joy2         (joy2),
    .Y            (Y),
    .X            (X),
    .key_nmi      (key_nmi),
    .Fn           (Fn)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int nmi_cnt = 0;
  bit checking = 0;

  // Known keys: kind 0 = no mapping, 1 = matrix key, 2 = function key, 3 = F11
  typedef struct {
    bit         ext;
    logic [7:0] code;
    int         kind;
    int         row;
    int         col;
    int         fn;
  } kent_t;
  kent_t tbl[$];

  function automatic void add(bit ext, logic [7:0] c, int kind, int r, int col, int fn);
    kent_t e;
    e.ext = ext; e.code = c; e.kind = kind; e.row = r; e.col = col; e.fn = fn;
    tbl.push_back(e);
  endfunction

  function automatic int find(bit ext, logic [7:0] c);
    foreach (tbl[i]) if (tbl[i].ext == ext && tbl[i].code == c) return i;
    return -1;
  endfunction

  // Model state: key rows active-low, Fn levels, F11 held, pending event
  logic [7:0] m_mat[10];
  logic [9:0] m_fn;
  bit         m_f11;
  bit         m_nmi;
  bit         pend_v;
  bit         pend_ext;
  bit         pend_prs;
  logic [7:0] pend_code;

  // An event seen on one edge takes effect on the following edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 10; r++) m_mat[r] <= 8'hFF;
      m_fn   <= '0;
      m_f11  <= 1'b0;
      m_nmi  <= 1'b0;
      pend_v <= 1'b0;
    end else begin
      int k;
      k = pend_v ? find(pend_ext, pend_code) : -1;
      m_nmi <= 1'b0;
      if (k >= 0) begin
        case (tbl[k].kind)
          1: m_mat[tbl[k].row][tbl[k].col] <= ~pend_prs;
          2: m_fn[tbl[k].fn] <= pend_prs;
          3: begin
            if (pend_prs && !m_f11) m_nmi <= 1'b1;
            m_f11 <= pend_prs;
          end
          default: ;
        endcase
      end
      pend_v    <= key_strobe;
      pend_ext  <= key_extended;
      pend_code <= key_code;
      pend_prs  <= key_pressed;
    end
  end

  // Joystick pressed lines placed at their matrix bit positions
  function automatic logic [7:0] joy_bits(logic [6:0] j);
    return {2'b00, j[4], j[5], j[0], j[1], j[2], j[3]};
  endfunction

  function automatic logic [7:0] exp_x(logic [3:0] y, logic [6:0] j1, logic [6:0] j2);
    logic [7:0] v;
    v = (y < 4'd10) ? m_mat[y] : 8'hFF;
    if (y == 4'd9) v = v & ~joy_bits(j1);
    if (y == 4'd6) v = v & ~joy_bits(j2);
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      check("x_model", 32'(X), 32'(exp_x(Y, joy1, joy2)));
      check("fn_model", 32'(Fn), 32'(m_fn));
      check("nmi_model", 32'(key_nmi), 32'(m_nmi));
    end
  end

  always @(negedge clk) if (key_nmi === 1'b1) nmi_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(bit ext, logic [7:0] c, bit prs);
    key_extended = ext;
    key_code     = c;
    key_pressed  = prs;
    key_strobe   = 1'b1;
    tick();
    key_strobe   = 1'b0;
  endtask

  // Select a row, compare X at the next falling edge, advance one cycle
  task automatic lit_x(string nm, logic [3:0] y, logic [7:0] e);
    Y = y;
    @(negedge clk);
    check(nm, 32'(X), 32'(e));
    tick();
  endtask

  initial begin
    int n0;
    int n1;
    add(1, 8'h75, 1, 0, 0, 0);
    add(0, 8'h5A, 1, 2, 2, 0);
    add(0, 8'h29, 1, 5, 7, 0);
    add(0, 8'h76, 1, 8, 2, 0);
    add(0, 8'h1C, 1, 8, 5, 0);
    add(0, 8'h05, 2, 0, 0, 0);
    add(0, 8'h06, 2, 0, 0, 1);
    add(0, 8'h04, 2, 0, 0, 2);
    add(0, 8'h0C, 2, 0, 0, 3);
    add(0, 8'h03, 2, 0, 0, 4);
    add(0, 8'h0B, 2, 0, 0, 5);
    add(0, 8'h83, 2, 0, 0, 6);
    add(0, 8'h0A, 2, 0, 0, 7);
    add(0, 8'h01, 2, 0, 0, 8);
    add(0, 8'h09, 2, 0, 0, 9);
    add(0, 8'h78, 3, 0, 0, 0);
    add(0, 8'h0F, 0, 0, 0, 0);
    add(1, 8'h0F, 0, 0, 0, 0);

    tick();
    checking = 1;
    Y = 4'd3;
    @(negedge clk);
    check("rst_x", 32'(X), 32'h0FF);
    check("rst_fn", 32'(Fn), 32'h000);
    check("rst_nmi", 32'(key_nmi), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Make A: matrix changes on the second edge, not the first
    send(0, 8'h1C, 1);
    lit_x("a_latency", 4'd8, 8'hFF);
    lit_x("a_make", 4'd8, 8'hDF);
    send(0, 8'h1C, 0);
    tick();
    lit_x("a_break", 4'd8, 8'hFF);

    // Back-to-back: Space then cursor up
    send(0, 8'h29, 1);
    send(1, 8'h75, 1);
    lit_x("space_row5", 4'd5, 8'h7F);
    lit_x("up_row0", 4'd0, 8'hFE);
    lit_x("kp8_row1", 4'd1, 8'hFF);
    send(0, 8'h29, 0);
    send(1, 8'h75, 0);
    tick();

    // Joystick overlay
    joy1 = 7'h11;
    lit_x("joy1_rf", 4'd9, 8'hD7);
    joy1 = 7'h00;
    lit_x("joy1_off", 4'd9, 8'hFF);
    lit_x("row12", 4'd12, 8'hFF);
    joy2 = 7'h11;
    lit_x("joy2_rf", 4'd6, 8'hD7);
    joy2 = 7'h00;
    tick();

    // F11 NMI edge detection
    n0 = nmi_cnt;
    send(0, 8'h78, 1);
    send(0, 8'h78, 1);
    send(0, 8'h78, 1);
    repeat (3) tick();
    check("nmi_once", 32'(nmi_cnt - n0), 32'd1);
    send(0, 8'h78, 0);
    send(0, 8'h78, 1);
    repeat (3) tick();
    check("nmi_rearm", 32'(nmi_cnt - n0), 32'd2);

    // F1 level, then reset with a Return make in flight
    send(0, 8'h05, 1);
    tick();
    @(negedge clk);
    check("fn_f1", 32'(Fn), 32'h001);
    tick();
    n1 = nmi_cnt;
    send(0, 8'h5A, 1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    for (int y = 0; y < 10; y++) lit_x("rst_row", 4'(y), 8'hFF);
    @(negedge clk);
    check("rst_fn_clear", 32'(Fn), 32'h000);
    check("rst_no_nmi", 32'(nmi_cnt - n1), 32'd0);
    tick();
    send(0, 8'h78, 1);
    repeat (3) tick();
    check("nmi_after_rst", 32'(nmi_cnt - n1), 32'd1);
    send(0, 8'h78, 0);
    tick();

    // Unmapped code
    send(0, 8'h0F, 1);
    tick();
    for (int y = 0; y < 10; y++) lit_x("unmapped_row", 4'(y), 8'hFF);

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      kent_t e;
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      else if (reset && $urandom_range(0, 1) == 0) reset = 1'b0;
      e = tbl[$urandom_range(0, tbl.size() - 1)];
      key_strobe   = ($urandom_range(0, 1) == 1);
      key_extended = e.ext;
      key_code     = e.code;
      key_pressed  = ($urandom_range(0, 2) != 0);
      Y    = 4'($urandom_range(0, 15));
      joy1 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      joy2 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      tick();
    end
    reset = 1'b0;
    key_strobe = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
